// File: rtl/ram_pkg.sv
// Shared types and constants for the synchronous-clear RAM block.
// State encoding for the clear sequencer and the rw request encoding.
package ram_pkg;

  typedef enum logic {
    RAM_CLEAR = 1'b0,
    RAM_READY = 1'b1
  } ram_state_t;

  localparam logic RAM_RD = 1'b0;
  localparam logic RAM_WR = 1'b1;

endpackage

// File: rtl/ram_clear_ctr.sv
// Sweep address counter for the RAM clear sequence; flags the final word.
// Latency: cnt updates on the edge after step; last is combinational on cnt.
// Backpressure: none; clr forces cnt to 0 and holds it there while high.
module ram_clear_ctr #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          step,
  output logic [AW-1:0] cnt,
  output logic          last
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  assign last = (cnt == LAST_ADDR);

  // Parks on the last address once reached; the next clr restarts it.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (step && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram_sync_clr.sv
// Single-port RAM with registered read and a hardware zeroing sweep after clr.
// Latency: read data and valid one edge after the request; writes commit at the request edge.
// Backpressure: none besides busy; requests during the sweep are dropped.
module ram_sync_clr
  import ram_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             rw,
  input  logic [AW-1:0]    address,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] o,
  output logic             valid,
  output logic             busy
);

  localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  ram_state_t       state;
  logic [AW-1:0]    cnt;
  logic             last;
  logic             sweeping;
  logic             in_range;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_dat;
  logic [WIDTH-1:0] rd_dat;

  assign sweeping = (state == RAM_CLEAR);

  ram_clear_ctr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ctr (
    .clk  (clk),
    .clr  (clr),
    .step (sweeping),
    .cnt  (cnt),
    .last (last)
  );

  // Only non-power-of-two depths can see an address past the array end.
  assign in_range = ({1'b0, address} < DEPTH_X);

  // The sweep and user writes share the single write port.
  assign wr_en   = !clr && (sweeping || (en && (rw == RAM_WR) && in_range));
  assign wr_addr = sweeping ? cnt : address;
  assign wr_dat  = sweeping ? '0 : data;
  assign rd_dat  = in_range ? mem[address] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= RAM_CLEAR;
      busy  <= 1'b1;
      o     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        RAM_CLEAR: begin
          if (last) begin
            state <= RAM_READY;
            busy  <= 1'b0;
          end
        end
        RAM_READY: begin
          if (en && (rw == RAM_RD)) begin
            o     <= rd_dat;
            valid <= 1'b1;
          end
        end
        default: begin
          state <= RAM_CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sync_clr.sv
// Bench for ram_sync_clr: a DEPTH=16 and a DEPTH=12 instance share one stimulus stream
// and are compared every cycle against an array-based reference model.
module tb_ram_sync_clr;

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic       rw;
  logic [3:0] address;
  logic [7:0] data;
  logic [7:0] o0, o1;
  logic       valid0, valid1, busy0, busy1;

  int compared   = 0;
  int mismatched = 0;

  // Reference model, index 0 = DEPTH 16, index 1 = DEPTH 12.
  int         dep [2] = '{16, 12};
  logic [7:0] mm  [2][16];
  int         cl  [2];
  logic [7:0] mo  [2];
  logic       mv  [2];

  always #5 clk = ~clk;

  ram_sync_clr #(.WIDTH(8), .DEPTH(16)) dut0 (
    .clk(clk), .clr(clr), .en(en), .rw(rw), .address(address), .data(data),
    .o(o0), .valid(valid0), .busy(busy0)
  );

  ram_sync_clr #(.WIDTH(8), .DEPTH(12)) dut1 (
    .clk(clk), .clr(clr), .en(en), .rw(rw), .address(address), .data(data),
    .o(o1), .valid(valid1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        cl[k] = dep[k];
        mo[k] = 8'h00;
        mv[k] = 1'b0;
      end else if (cl[k] > 0) begin
        cl[k]--;
        mv[k] = 1'b0;
        if (cl[k] == 0)
          for (int j = 0; j < 16; j++) mm[k][j] = 8'h00;
      end else if (en) begin
        if (rw) begin
          if (int'(address) < dep[k]) mm[k][address] = data;
          mv[k] = 1'b0;
        end else begin
          mo[k] = (int'(address) < dep[k]) ? mm[k][address] : 8'h00;
          mv[k] = 1'b1;
        end
      end else begin
        mv[k] = 1'b0;
      end
    end
  endtask

  // One clock edge: advance the model with the applied inputs, then compare.
  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    chk("busy16",  32'(busy0),  32'(cl[0] > 0));
    chk("valid16", 32'(valid0), 32'(mv[0]));
    chk("o16",     32'(o0),     32'(mo[0]));
    chk("busy12",  32'(busy1),  32'(cl[1] > 0));
    chk("valid12", 32'(valid1), 32'(mv[1]));
    chk("o12",     32'(o1),     32'(mo[1]));
    chk("busy_valid_excl", 32'(busy0 & valid0), 32'(0));
  endtask

  task automatic req(input logic e, input logic w, input logic [3:0] a, input logic [7:0] d);
    en = e; rw = w; address = a; data = d;
    tick();
  endtask

  // Counts edges until busy0 drops, bounded so a stuck sweep cannot hang the run.
  task automatic wait_ready(output int n);
    n = 0;
    while (busy0 && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    clr = 1'b1; en = 1'b0; rw = 1'b0; address = 4'd0; data = 8'h00;
    for (int k = 0; k < 2; k++) begin
      cl[k] = 0; mo[k] = 8'h00; mv[k] = 1'b0;
      for (int j = 0; j < 16; j++) mm[k][j] = 8'h00;
    end

    // Reset state and a full sweep of exactly DEPTH edges.
    tick();
    clr = 1'b0;
    chk("reset_busy", 32'(busy0), 32'(1));
    chk("reset_o",    32'(o0),    32'(0));
    wait_ready(n);
    chk("sweep_len16", 32'(n), 32'(16));
    for (int i = 0; i < 16; i++) begin
      req(1'b1, 1'b0, 4'(i), 8'h00);
      chk("rd_cleared_o", 32'(o0), 32'(0));
      chk("rd_cleared_v", 32'(valid0), 32'(1));
    end

    // Writes then reads with idle cycles in between.
    req(1'b1, 1'b1, 4'd3, 8'h0C);
    chk("wr_no_valid", 32'(valid0), 32'(0));
    req(1'b1, 1'b1, 4'd5, 8'hAA);
    req(1'b1, 1'b0, 4'd3, 8'h00);
    chk("rd3", 32'(o0), 32'(8'h0C));
    req(1'b0, 1'b0, 4'd0, 8'h00);
    chk("idle_hold_o", 32'(o0), 32'(8'h0C));
    chk("idle_valid",  32'(valid0), 32'(0));
    req(1'b0, 1'b0, 4'd0, 8'h00);
    req(1'b1, 1'b0, 4'd5, 8'h00);
    chk("rd5", 32'(o0), 32'(8'hAA));

    // Write-then-read on consecutive edges.
    req(1'b1, 1'b1, 4'd15, 8'h0A);
    req(1'b1, 1'b0, 4'd15, 8'h00);
    chk("rd15_b2b", 32'(o0), 32'(8'h0A));

    // Requests during the sweep are ignored.
    clr = 1'b1; en = 1'b0;
    tick();
    clr = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin
      req(1'b1, 1'b1, 4'd2, 8'hFF);
      n++;
    end
    chk("sweep_len_busy_wr", 32'(n), 32'(16));
    req(1'b1, 1'b0, 4'd2, 8'h00);
    chk("rd2_after_busy_wr", 32'(o0), 32'(0));

    // Mid-sweep clr at cnt == 7 restarts the full sweep.
    req(1'b1, 1'b1, 4'd9, 8'h99);
    clr = 1'b1; en = 1'b0;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_ready(n);
    chk("restart_len16", 32'(n), 32'(16));
    for (int i = 0; i < 16; i++) begin
      req(1'b1, 1'b0, 4'(i), 8'h00);
      chk("rd_restart", 32'(o0), 32'(0));
    end

    // Out-of-range access on the DEPTH=12 instance and aliasing probes.
    req(1'b1, 1'b1, 4'd13, 8'h55);
    req(1'b1, 1'b0, 4'd13, 8'h00);
    chk("oor_rd_o",  32'(o1), 32'(0));
    chk("oor_rd_v",  32'(valid1), 32'(1));
    chk("in16_rd13", 32'(o0), 32'(8'h55));
    req(1'b1, 1'b0, 4'd11, 8'h00);
    chk("rd11_12", 32'(o1), 32'(0));
    req(1'b1, 1'b0, 4'd5, 8'h00);
    chk("alias5_12", 32'(o1), 32'(0));
    req(1'b1, 1'b0, 4'd1, 8'h00);
    chk("alias1_12", 32'(o1), 32'(0));

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 600; i++) begin
      clr     = ($urandom_range(0, 59) == 0);
      en      = 1'($urandom_range(0, 3) != 0);
      rw      = 1'($urandom_range(0, 1));
      address = 4'($urandom_range(0, 15));
      data    = 8'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
